// File: rtl/osc_freq_meter_pkg.sv
// Shared definitions for the ring-oscillator frequency meter: FSM states and
// gate-window length helper.
package osc_freq_meter_pkg;

  localparam int GATE_LOG2_MIN = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Gate window in clk cycles: 2^(log2_min + 2*gate_sel).
  function automatic int unsigned gate_len(input logic [1:0] gate_sel,
                                           input int unsigned log2_min = GATE_LOG2_MIN);
    return 32'd1 << (log2_min + 2 * int'(gate_sel));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous levels into the
// local clock domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/osc_freq_meter.sv
// Counts rising edges of one bit of the oscillator-domain counter over a
// programmable gate window and reports the count with overflow flag.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | waiting for ena & start
// ARM     | two cycles flushing the synchronizer; clear counters, load gate
// MEASURE | counting synchronized tap edges while the gate counts down
// DONE    | one cycle, result valid; rearm in continuous mode
module osc_freq_meter
  import osc_freq_meter_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int MEAS_W        = 16,
  parameter int GATE_LOG2_MIN = osc_freq_meter_pkg::GATE_LOG2_MIN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [CNT_W-1:0]  osc_cnt,
  input  logic [2:0]        tap_sel,
  input  logic [1:0]        gate_sel,
  input  logic              start,
  input  logic              cont,
  output logic [MEAS_W-1:0] result,
  output logic              result_ovf,
  output logic              result_valid,
  output logic              busy
);

  localparam int GATE_W = GATE_LOG2_MIN + 6;
  localparam logic [MEAS_W-1:0] MEAS_MAX = '1;

  state_t             state, state_nxt;
  logic               latch_cfg;
  logic               arm_second;
  logic [2:0]         tap_sel_q;
  logic [1:0]         gate_sel_q;

  logic               tap_raw;
  logic               tap_s2;
  logic               tap_s3;
  logic               osc_edge;

  logic [GATE_W-1:0]  gate_cnt;
  logic [GATE_W-1:0]  gate_load;
  logic               gate_done;

  logic [MEAS_W-1:0]  edge_cnt;
  logic [MEAS_W-1:0]  cnt_inc;
  logic               ovf;
  logic               ovf_inc;

  // Tap mux; indices beyond the counter width read as 0.
  always_comb begin
    tap_raw = 1'b0;
    for (int i = 0; i < CNT_W; i++) begin
      if (i < 8 && tap_sel_q == 3'(i)) tap_raw = osc_cnt[i];
    end
  end

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (tap_raw),
    .q     (tap_s2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tap_s3 <= 1'b0;
    else        tap_s3 <= tap_s2;
  end

  assign osc_edge  = tap_s2 & ~tap_s3;
  assign gate_load = GATE_W'(gate_len(gate_sel_q, GATE_LOG2_MIN) - 32'd1);
  assign gate_done = (gate_cnt == '0);

  // Saturating increment; an edge arriving at full scale marks overflow.
  always_comb begin
    cnt_inc = edge_cnt;
    ovf_inc = ovf;
    if (osc_edge) begin
      if (edge_cnt == MEAS_MAX) ovf_inc = 1'b1;
      else                      cnt_inc = edge_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    latch_cfg = 1'b0;
    if (!ena) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt = ST_ARM;
            latch_cfg = 1'b1;
          end
        end
        ST_ARM: begin
          if (arm_second) state_nxt = ST_MEASURE;
        end
        ST_MEASURE: begin
          if (gate_done) state_nxt = ST_DONE;
        end
        ST_DONE: begin
          if (cont) begin
            state_nxt = ST_ARM;
            latch_cfg = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tap_sel_q  <= '0;
      gate_sel_q <= '0;
      arm_second <= 1'b0;
    end else begin
      state      <= state_nxt;
      arm_second <= ena && (state == ST_ARM) && !arm_second;
      if (latch_cfg) begin
        tap_sel_q  <= tap_sel;
        gate_sel_q <= gate_sel;
      end
    end
  end

  // Counters and result only move while enabled; an abort freezes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf        <= 1'b0;
      result     <= '0;
      result_ovf <= 1'b0;
    end else if (ena) begin
      unique case (state)
        ST_ARM: begin
          edge_cnt <= '0;
          ovf      <= 1'b0;
          gate_cnt <= gate_load;
        end
        ST_MEASURE: begin
          edge_cnt <= cnt_inc;
          ovf      <= ovf_inc;
          if (gate_done) begin
            result     <= cnt_inc;
            result_ovf <= ovf_inc;
          end else begin
            gate_cnt <= gate_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_valid = (state == ST_DONE);
  assign busy         = (state != ST_IDLE);

endmodule
